// File: rtl/tof_pkg.sv
// Shared types and default widths for the echo time-of-flight detector.
package tof_pkg;

   localparam int N_DEFAULT  = 16;
   localparam int CW_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BLANK  = 2'd1,
      ST_LISTEN = 2'd2,
      ST_DONE   = 2'd3
   } tof_state_e;

endpackage

// File: rtl/echo_tof_detector_abs_sat.sv
// Combinational saturating absolute value of an N-bit two's-complement sample.
module abs_sat
   import tof_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic [N-1:0] x,
   output logic [N-1:0] a
);

   localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0] MOST_POS = {1'b0, {(N-1){1'b1}}};

   // The most negative code has no positive twin, so it clamps to the largest positive value.
   always_comb begin
      a = x;
      if (x == MOST_NEG) begin
         a = MOST_POS;
      end else if (x[N-1]) begin
         a = (~x) + {{(N-1){1'b0}}, 1'b1};
      end else begin
         a = x;
      end
   end

endmodule

// File: rtl/echo_tof_detector.sv
// Echo time-of-flight detector: blanks ring-down, then reports the first |X| >= threshold sample.
// Optional build macro PEAK_CAPTURE_EN adds a running max |X| over the listen window on port peak.
module echo_tof_detector
   import tof_pkg::*;
#(
   parameter int N  = N_DEFAULT,
   parameter int CW = CW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          en,
   input  logic [N-1:0]  X,
   input  logic [N-1:0]  threshold,
   input  logic [CW-1:0] blank_len,
   input  logic [CW-1:0] window_len,
   output logic [CW-1:0] tof,
   output logic [N-1:0]  peak,
   output logic          valid,
   output logic          timeout,
   output logic          busy
);

   tof_state_e    state_r, state_next_s;
   logic [CW:0]   cnt_r, cnt_plus1_s, limit_s;
   logic [N-1:0]  thr_r, a_s;
   logic [CW-1:0] blank_r, window_r, tof_sat_s, tof_r;
   logic          valid_r, timeout_r, busy_r;
   logic          load_s, cnt_inc_s, hit_s, tmo_s;

   abs_sat #(.N(N)) u_abs (
      .x (X),
      .a (a_s)
   );

   assign cnt_plus1_s = cnt_r + {{CW{1'b0}}, 1'b1};
   assign limit_s     = {1'b0, blank_r} + {1'b0, window_r};

   // Sample index is reported saturated when the extended counter has run past CW bits.
   always_comb begin
      tof_sat_s = cnt_r[CW-1:0];
      if (cnt_r[CW]) begin
         tof_sat_s = {CW{1'b1}};
      end else begin
         tof_sat_s = cnt_r[CW-1:0];
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic and datapath strobes.
   always_comb begin
      state_next_s = state_r;
      load_s       = 1'b0;
      cnt_inc_s    = 1'b0;
      hit_s        = 1'b0;
      tmo_s        = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               load_s = 1'b1;
               if (blank_len == {CW{1'b0}}) begin
                  state_next_s = ST_LISTEN;
               end else begin
                  state_next_s = ST_BLANK;
               end
            end else begin
               state_next_s = state_r;
            end
         end
         ST_BLANK: begin
            if (en) begin
               cnt_inc_s = 1'b1;
               if (cnt_plus1_s == {1'b0, blank_r}) begin
                  state_next_s = ST_LISTEN;
               end else begin
                  state_next_s = ST_BLANK;
               end
            end else begin
               state_next_s = ST_BLANK;
            end
         end
         ST_LISTEN: begin
            // An empty window closes immediately, without looking at the sample stream.
            if (window_r == {CW{1'b0}}) begin
               tmo_s        = 1'b1;
               state_next_s = ST_DONE;
            end else if (en) begin
               if (a_s >= thr_r) begin
                  hit_s        = 1'b1;
                  state_next_s = ST_DONE;
               end else begin
                  cnt_inc_s = 1'b1;
                  if (cnt_plus1_s == limit_s) begin
                     tmo_s        = 1'b1;
                     state_next_s = ST_DONE;
                  end else begin
                     state_next_s = ST_LISTEN;
                  end
               end
            end else begin
               state_next_s = ST_LISTEN;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Latched configuration, sample counter and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         thr_r     <= {N{1'b0}};
         blank_r   <= {CW{1'b0}};
         window_r  <= {CW{1'b0}};
         cnt_r     <= {(CW+1){1'b0}};
         tof_r     <= {CW{1'b0}};
         valid_r   <= 1'b0;
         timeout_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         busy_r <= (state_next_s == ST_BLANK) || (state_next_s == ST_LISTEN);
         if (load_s) begin
            thr_r     <= threshold;
            blank_r   <= blank_len;
            window_r  <= window_len;
            cnt_r     <= {(CW+1){1'b0}};
            tof_r     <= {CW{1'b0}};
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
         end else begin
            if (cnt_inc_s) begin
               cnt_r <= cnt_plus1_s;
            end
            if (hit_s) begin
               tof_r   <= tof_sat_s;
               valid_r <= 1'b1;
            end
            if (tmo_s) begin
               timeout_r <= 1'b1;
            end
         end
      end
   end

`ifdef PEAK_CAPTURE_EN
   logic [N-1:0] peak_r;
   logic         peak_upd_s;

   assign peak_upd_s = (state_r == ST_LISTEN) && en && (window_r != {CW{1'b0}});

   // Running max of |X| over listen samples, including the crossing sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak_r <= {N{1'b0}};
      end else if (load_s) begin
         peak_r <= {N{1'b0}};
      end else if (peak_upd_s && (a_s > peak_r)) begin
         peak_r <= a_s;
      end
   end

   assign peak = peak_r;
`else
   assign peak = {N{1'b0}};
`endif

   assign tof     = tof_r;
   assign valid   = valid_r;
   assign timeout = timeout_r;
   assign busy    = busy_r;

endmodule

// File: tb/tb_echo_tof_detector.sv
// Directed self-checking bench for echo_tof_detector; expectations follow PEAK_CAPTURE_EN.
module tb_echo_tof_detector;

   logic        clk = 1'b0;
   logic        rst_n, start, en;
   logic [15:0] X, threshold, blank_len, window_len;
   logic [15:0] tof, peak;
   logic        valid, timeout, busy;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_peak;

   echo_tof_detector #(.N(16), .CW(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .en         (en),
      .X          (X),
      .threshold  (threshold),
      .blank_len  (blank_len),
      .window_len (window_len),
      .tof        (tof),
      .peak       (peak),
      .valid      (valid),
      .timeout    (timeout),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic cfg(input logic [15:0] thr, input logic [15:0] bl, input logic [15:0] wl);
      threshold  = thr;
      blank_len  = bl;
      window_len = wl;
   endtask

   // One clock with the given inputs; returns 1 time unit after the rising edge.
   task automatic step(input logic e, input logic [15:0] x, input logic s);
      en    = e;
      X     = x;
      start = s;
      @(posedge clk);
      #1;
      en    = 1'b0;
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; en = 1'b0; X = 16'd0;
      cfg(16'd0, 16'd0, 16'd0);
      #2;
      n_cmp++; if (tof !== 16'd0)   begin n_err++; $display("FAIL reset_tof: got %0d want 0", tof); end
      n_cmp++; if (peak !== 16'd0)  begin n_err++; $display("FAIL reset_peak: got %0d want 0", peak); end
      n_cmp++; if (valid !== 1'b0)  begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
      n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", timeout); end
      n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      #6 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_echo;
      logic [15:0] xs [7];
      xs = '{16'd500, 16'd500, 16'd500, 16'd20, 16'd20, 16'd20, 16'd150};
      cfg(16'd100, 16'd3, 16'd10);
      step(1'b0, 16'd0, 1'b1);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL echo_busy_start: got %b want 1", busy); end
      for (int i = 0; i < 7; i++) begin
         step(1'b1, xs[i], 1'b0);
         step(1'b0, 16'd999, 1'b0);  // idle gap with a loud sample must be ignored
         if (i == 5) begin
            n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL echo_early_valid: got %b want 0", valid); end
         end
      end
      exp_peak = 16'd0;
`ifdef PEAK_CAPTURE_EN
      exp_peak = 16'd150;
`endif
      n_cmp++; if (valid !== 1'b1)   begin n_err++; $display("FAIL echo_valid: got %b want 1", valid); end
      n_cmp++; if (tof !== 16'd6)    begin n_err++; $display("FAIL echo_tof: got %0d want 6", tof); end
      n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL echo_timeout: got %b want 0", timeout); end
      n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL echo_busy_end: got %b want 0", busy); end
      n_cmp++; if (peak !== exp_peak) begin n_err++; $display("FAIL echo_peak: got %0d want %0d", peak, exp_peak); end
      step(1'b1, 16'd700, 1'b0);
      step(1'b1, 16'd700, 1'b0);
      n_cmp++; if (tof !== 16'd6 || valid !== 1'b1) begin n_err++; $display("FAIL echo_hold: got tof=%0d valid=%b want 6/1", tof, valid); end
   endtask

   task automatic test_negative;
      cfg(16'd100, 16'd3, 16'd10);
      step(1'b0, 16'd0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 16'd500, 1'b0);
      step(1'b1, 16'd0, 1'b0);
      step(1'b1, 16'hFF38, 1'b0);  // -200
      exp_peak = 16'd0;
`ifdef PEAK_CAPTURE_EN
      exp_peak = 16'd200;
`endif
      n_cmp++; if (valid !== 1'b1 || tof !== 16'd4) begin n_err++; $display("FAIL neg_cross: got valid=%b tof=%0d want 1/4", valid, tof); end
      n_cmp++; if (peak !== exp_peak) begin n_err++; $display("FAIL neg_peak: got %0d want %0d", peak, exp_peak); end
      // -32768 saturates to 32767, which stays below a 0x8000 threshold
      cfg(16'h8000, 16'd0, 16'd1);
      step(1'b0, 16'd0, 1'b1);
      step(1'b1, 16'h8000, 1'b0);
      exp_peak = 16'd0;
`ifdef PEAK_CAPTURE_EN
      exp_peak = 16'd32767;
`endif
      n_cmp++; if (timeout !== 1'b1 || valid !== 1'b0) begin n_err++; $display("FAIL sat_below: got timeout=%b valid=%b want 1/0", timeout, valid); end
      n_cmp++; if (peak !== exp_peak) begin n_err++; $display("FAIL sat_peak: got %0d want %0d", peak, exp_peak); end
      cfg(16'd32767, 16'd0, 16'd1);
      step(1'b0, 16'd0, 1'b1);
      step(1'b1, 16'h8000, 1'b0);
      n_cmp++; if (valid !== 1'b1 || tof !== 16'd0) begin n_err++; $display("FAIL sat_cross: got valid=%b tof=%0d want 1/0", valid, tof); end
   endtask

   task automatic test_timeout;
      cfg(16'd100, 16'd2, 16'd5);
      step(1'b0, 16'd0, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, 16'd10, 1'b0);
      n_cmp++; if (timeout !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL tmo_early: got timeout=%b busy=%b want 0/1", timeout, busy); end
      step(1'b1, 16'd10, 1'b0);
      n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL tmo_flag: got %b want 1", timeout); end
      n_cmp++; if (valid !== 1'b0)   begin n_err++; $display("FAIL tmo_valid: got %b want 0", valid); end
      n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL tmo_busy: got %b want 0", busy); end
   endtask

   task automatic test_reset_mid;
      cfg(16'd100, 16'd3, 16'd10);
      step(1'b0, 16'd0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 16'd10, 1'b0);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
      #2;
      en = 1'b1; X = 16'd10; rst_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0 || valid !== 1'b0 || timeout !== 1'b0 || tof !== 16'd0 || peak !== 16'd0) begin
         n_err++; $display("FAIL rmid_async: got busy=%b valid=%b timeout=%b tof=%0d peak=%0d want all 0", busy, valid, timeout, tof, peak);
      end
      @(posedge clk);
      #1;
      en = 1'b0; rst_n = 1'b1;
      step(1'b0, 16'd0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 16'd0, 1'b0);
      step(1'b1, 16'd300, 1'b0);
      n_cmp++; if (valid !== 1'b1 || tof !== 16'd3) begin n_err++; $display("FAIL rmid_restart: got valid=%b tof=%0d want 1/3", valid, tof); end
   endtask

   task automatic test_start_rules;
      cfg(16'd100, 16'd3, 16'd10);
      step(1'b0, 16'd0, 1'b1);
      step(1'b1, 16'd0, 1'b0);
      step(1'b1, 16'd0, 1'b0);
      cfg(16'd5, 16'd0, 16'd10);
      step(1'b0, 16'd0, 1'b1);     // ignored while busy
      step(1'b1, 16'd50, 1'b0);
      step(1'b1, 16'd50, 1'b0);
      n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL busy_start_valid: got %b want 0", valid); end
      step(1'b1, 16'd100, 1'b0);   // equality counts as a crossing
      n_cmp++; if (valid !== 1'b1 || tof !== 16'd4) begin n_err++; $display("FAIL busy_start_tof: got valid=%b tof=%0d want 1/4", valid, tof); end
      cfg(16'd100, 16'd0, 16'd10);
      step(1'b1, 16'd500, 1'b1);   // en with start is not sample 0
      n_cmp++; if (valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL start_en_valid: got valid=%b busy=%b want 0/1", valid, busy); end
      step(1'b1, 16'd500, 1'b0);
      n_cmp++; if (valid !== 1'b1 || tof !== 16'd0) begin n_err++; $display("FAIL start_en_tof: got valid=%b tof=%0d want 1/0", valid, tof); end
   endtask

   task automatic test_window0;
      cfg(16'd100, 16'd1, 16'd0);
      step(1'b0, 16'd0, 1'b1);
      step(1'b1, 16'd500, 1'b0);
      n_cmp++; if (busy !== 1'b1 || timeout !== 1'b0) begin n_err++; $display("FAIL win0_pre: got busy=%b timeout=%b want 1/0", busy, timeout); end
      step(1'b1, 16'd500, 1'b0);
      n_cmp++; if (timeout !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL win0_tmo: got timeout=%b valid=%b busy=%b want 1/0/0", timeout, valid, busy);
      end
   endtask

   task automatic test_peak;
      cfg(16'd110, 16'd0, 16'd10);
      step(1'b0, 16'd0, 1'b1);
      step(1'b1, 16'd40, 1'b0);
      step(1'b1, 16'd90, 1'b0);
      step(1'b1, 16'hFF88, 1'b0);  // -120
      exp_peak = 16'd0;
`ifdef PEAK_CAPTURE_EN
      exp_peak = 16'd120;
`endif
      n_cmp++; if (valid !== 1'b1 || tof !== 16'd2) begin n_err++; $display("FAIL peak_tof: got valid=%b tof=%0d want 1/2", valid, tof); end
      n_cmp++; if (peak !== exp_peak) begin n_err++; $display("FAIL peak_val: got %0d want %0d", peak, exp_peak); end
      step(1'b0, 16'd0, 1'b1);
      n_cmp++; if (peak !== 16'd0 || valid !== 1'b0) begin n_err++; $display("FAIL peak_clear: got peak=%0d valid=%b want 0/0", peak, valid); end
   endtask

   initial begin
      test_reset;
      test_echo;
      test_negative;
      test_timeout;
      test_reset_mid;
      test_start_rules;
      test_window0;
      test_peak;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
